// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 encodings, FSM states and decode helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} lsu_state_t;
  function automatic logic [2:0] f3_size(input logic [1:0] sz);
    return sz == 2'b00 ? 3'd1 : sz == 2'b01 ? 3'd2 : 3'd4;
  endfunction
  function automatic logic f3_bad(input logic we, input logic [2:0] f3);
    return we ? (f3[2] || f3[1:0] == 2'b11) : (f3 == 3'b011 || f3[2:1] == 2'b11);
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: pipeline request/response and data-memory port bundle for lsu_ctrl
interface lsu_if #(parameter int MEM_AW = 12);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts the {word1,word0} pair down by the byte offset and extends per funct3
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);
  logic [31:0] sh;
  assign sh = 32'(dword >> {off, 3'b000});
  always_comb
    rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
            funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
            funct3 == F3_BU ? {24'h0, sh[7:0]} :
            funct3 == F3_HU ? {16'h0, sh[15:0]} : sh;
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit FSM; splits word-crossing accesses, or traps them when
// LSU_MISALIGN_TRAP_EN is defined.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_BYTES = 4096,
  parameter int MEM_AW      = 12
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  localparam int WW = MEM_AW - 2;
  lsu_state_t  state, state_n;
  logic        we_q, err_q, split_q, accept, acc, mis, split, err;
  logic [2:0]  f3_q, size;
  logic [1:0]  off_q;
  logic [WW-1:0] widx_q;
  logic [31:0] wdata_q, w0_q, rdata_q, ld;
  logic [32:0] last;
  logic [3:0]  mask;
  logic [7:0]  be8;
  logic [63:0] wd64;
  assign size   = f3_size(bus.req_funct3[1:0]);
  assign last   = {1'b0, bus.req_addr} + 33'(size) - 33'd1;
`ifdef LSU_MISALIGN_TRAP_EN
  assign mis    = |(bus.req_addr[1:0] & 2'(size - 3'd1));
  assign split  = 1'b0;
`else
  assign mis    = 1'b0;
  assign split  = 3'(bus.req_addr[1:0]) + size > 3'd4;
`endif
  assign err    = f3_bad(bus.req_we, bus.req_funct3) || last >= 33'(DEPTH_BYTES) || mis;
  assign accept = state == IDLE && bus.req_valid;
  // lanes and data of the whole access laid across the two-word window
  assign mask   = f3_q[1:0] == 2'b00 ? 4'h1 : f3_q[1:0] == 2'b01 ? 4'h3 : 4'hF;
  assign be8    = {4'h0, mask} << off_q;
  assign wd64   = {32'h0, wdata_q} << {off_q, 3'b000};
  // reset wins over an in-flight access so a pulsed rst cancels the pending write
  assign acc           = (state == ACC0 || state == ACC1) && !rst;
  assign bus.req_ready = state == IDLE;
  assign bus.mem_en    = acc;
  assign bus.mem_we    = acc && we_q;
  assign bus.mem_be    = acc ? (state == ACC1 ? be8[7:4] : be8[3:0]) : 4'h0;
  assign bus.mem_addr  = {widx_q + WW'(state == ACC1), 2'b00};
  assign bus.mem_wdata = state == ACC1 ? wd64[63:32] : wd64[31:0];
  assign bus.rsp_valid = state == RESP;
  assign bus.rsp_err   = state == RESP && err_q;
  assign bus.rsp_rdata = state == RESP ? rdata_q : 32'h0;
  lsu_load_align u_align (
    .dword  ({split_q ? bus.mem_rdata : 32'h0, split_q ? w0_q : bus.mem_rdata}),
    .off    (off_q),
    .funct3 (f3_q),
    .rdata  (ld)
  );
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.req_valid ? (err ? RESP : ACC0) : IDLE;
      ACC0:    state_n = split_q ? ACC1 : we_q ? RESP : CAP;
`ifndef LSU_MISALIGN_TRAP_EN
      ACC1:    state_n = we_q ? RESP : CAP;
`endif
      CAP:     state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state <= state_n;
      if (accept) begin
        we_q    <= bus.req_we;
        f3_q    <= bus.req_funct3;
        off_q   <= bus.req_addr[1:0];
        widx_q  <= bus.req_addr[MEM_AW-1:2];
        wdata_q <= bus.req_wdata;
        err_q   <= err;
        split_q <= split;
        rdata_q <= 32'h0;
      end
      if (state == ACC1) w0_q <= bus.mem_rdata;
      if (state == CAP) rdata_q <= ld;
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl against a byte-level reference memory
module tb_lsu_ctrl;
  import lsu_pkg::*;
  logic clk = 1'b0, rst = 1'b1, mem_init = 1'b1;
  always #5 clk = ~clk;
  lsu_if #(.MEM_AW(12)) bus ();
  lsu_ctrl #(.DEPTH_BYTES(4096), .MEM_AW(12)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {logic err; logic [31:0] rdata; int lat; int nacc; string tag;} exp_t;
  typedef struct {int t; logic we; logic [3:0] be; logic [11:0] addr; logic [31:0] wdata;} macc_t;
  exp_t  exp_q[$];
  int    acc_q[$];
  macc_t mlog[$];
  logic [7:0] mem [4096];
  logic [7:0] ref_mem [4096];
  int n_cmp = 0, n_bad = 0, ncyc = 0, last_acc = 0, last_rsp = 0, nacc = 0, busy_rdy = 0;
  bit busy = 0;

  function automatic logic [7:0] pat(int i);
    return 8'((i * 37 + 5) ^ (i >> 3));
  endfunction
  function automatic int sz(logic [2:0] f3);
    return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
  endfunction
  function automatic bit bad(bit we, logic [2:0] f3);
    return we ? !(f3 inside {3'b000, 3'b001, 3'b010}) : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  endfunction

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) mem[int'(bus.mem_addr) + b] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= {mem[int'(bus.mem_addr) + 3], mem[int'(bus.mem_addr) + 2],
                          mem[int'(bus.mem_addr) + 1], mem[int'(bus.mem_addr)]};
      end
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    ncyc++;
    if (rst) begin
      acc_q.delete();
      busy = 0;
    end else begin
      if (bus.mem_en) begin
        mlog.push_back('{ncyc, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata});
        nacc++;
      end
      if (busy && bus.req_ready) busy_rdy++;
      if (bus.rsp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk({e.tag, "_err"}, bus.rsp_err, e.err);
          chk({e.tag, "_rdata"}, bus.rsp_rdata, e.rdata);
          chk({e.tag, "_lat"}, ncyc - acc_q.pop_front(), e.lat);
          chk({e.tag, "_nacc"}, nacc, e.nacc);
          chk({e.tag, "_ready_busy"}, busy_rdy, 0);
        end
        busy = 0;
        last_rsp = ncyc;
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_q.push_back(ncyc);
        last_acc = ncyc;
        busy = 1;
        nacc = 0;
        busy_rdy = 0;
      end
    end
  end

  task automatic wait_ready(string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.req_ready && k < 50);
    if (!bus.req_ready) chk({tag, "_accept_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(string tag, bit we, logic [2:0] f3, int addr, logic [31:0] wd, bit hold = 0);
    int s = sz(f3);
    bit er, split;
    logic [31:0] v = 32'h0;
    er = bad(we, f3) || addr + s - 1 >= 4096;
`ifdef LSU_MISALIGN_TRAP_EN
    er = er || (addr % s) != 0;
`endif
    split = (addr % 4) + s > 4;
    if (!er && we) for (int i = 0; i < s; i++) ref_mem[addr + i] = wd[8*i +: 8];
    if (!er && !we) begin
      for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[addr + i];
      v = f3 == 3'b000 ? {{24{v[7]}}, v[7:0]} : f3 == 3'b001 ? {{16{v[15]}}, v[15:0]} : v;
    end
    exp_q.push_back('{er, (er || we) ? 32'h0 : v, er ? 1 : (we ? 2 : 3) + int'(split),
                      er ? 0 : 1 + int'(split), tag});
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = 32'(addr);
    bus.req_wdata  = wd;
    wait_ready(tag);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ml(string tag, int i, logic [3:0] be, logic [11:0] a, int dt,
                        logic [31:0] wd, logic [31:0] wm);
    if (mlog.size() <= i) chk({tag, "_missing"}, mlog.size(), i + 1);
    else begin
      chk({tag, "_be"}, mlog[i].be, be);
      chk({tag, "_addr"}, mlog[i].addr, a);
      chk({tag, "_dt"}, mlog[i].t - last_acc, dt);
      if (wm != 0) chk({tag, "_wdata"}, mlog[i].wdata & wm, wd & wm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_be", bus.mem_be, 0);
    @(posedge clk);
    #1;

    mlog.delete();
    issue("t1_sw", 1, F3_W, 'h10, 32'hDEADBEEF);
    drain();
    chk_ml("t1_mem", 0, 4'hF, 12'h010, 1, 32'hDEADBEEF, 32'hFFFFFFFF);
    issue("t1_lw", 0, F3_W, 'h10, 0);
    drain();

    mlog.delete();
    issue("t2_sb", 1, F3_B, 'h21, 32'h00000080);
    drain();
    chk_ml("t2_mem", 0, 4'b0010, 12'h020, 1, 32'h00008000, 32'h0000FF00);
    issue("t2_lb", 0, F3_B, 'h21, 0);
    issue("t2_lbu", 0, F3_BU, 'h21, 0);
    drain();

    mlog.delete();
    issue("t3_lw_split", 0, F3_W, 'h0E, 0);
    drain();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("t3_no_mem", mlog.size(), 0);
`else
    chk_ml("t3_w0", 0, 4'b1100, 12'h00C, 1, 32'h0, 32'h0);
    chk_ml("t3_w1", 1, 4'b0011, 12'h010, 2, 32'h0, 32'h0);
`endif

    issue("t4_ld_bad", 0, 3'b011, 'h20, 0);
    issue("t4_st_bad", 1, 3'b100, 'h20, 32'hFFFFFFFF);
    issue("t4_ld_bad7", 0, 3'b111, 'h20, 0);
    drain();

    issue("t5_range", 0, F3_W, 'hFFE, 0);
    issue("t5_lw_top", 0, F3_W, 'hFFC, 0);
    issue("t5_lb_top", 0, F3_B, 'hFFF, 0);
    issue("t5_lh_over", 0, F3_H, 'hFFF, 0);
    drain();

`ifndef LSU_MISALIGN_TRAP_EN
    mlog.delete();
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr = 32'h3;
    bus.req_wdata = 32'h11223344;
    wait_ready("t5_rst");
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_ready", bus.req_ready, 1);
    chk("t5_rst_nacc", mlog.size(), 1);
    chk_ml("t5_rst_w0", 0, 4'b1000, 12'h000, 1, 32'h44000000, 32'hFF000000);
    ref_mem[3] = 8'h44;
    @(posedge clk);
    #1;
    issue("t5_rd0", 0, F3_W, 'h0, 0);
    issue("t5_rd4", 0, F3_W, 'h4, 0);
    drain();
`endif

    issue("t6_sh", 1, F3_H, 'h40, 32'h0000A5C3, 1);
    issue("t6_lh", 0, F3_H, 'h40, 0, 1);
    chk("t6_gap", last_acc - last_rsp, 1);
    bus.req_valid = 1'b0;
    drain();

    for (int n = 0; n < 40; n++) begin
      issue("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 63)) + ((n % 5 == 0) ? 4032 : 128),
            $urandom, 1'($urandom_range(0, 1)));
    end
    bus.req_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
